// File: rtl/cube_scan_pkg.sv
// Shared types and constants for the cube scan controller.
// Optional feature macro: CUBE_SCAN_EARLY_EXIT_EN (stop the scan at the first hit).
package cube_scan_pkg;

  localparam int N_IN_DEFAULT = 14;

  // The onset count can reach 2^N_IN, so it needs one bit more than a vector.
  function automatic int count_width(input int n);
    return n + 1;
  endfunction

  localparam int COUNT_W = count_width(N_IN_DEFAULT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cube_eval.sv
// Combinational cube membership test: f=1 when every cared-for bit of vec
// equals the corresponding literal polarity.
module cube_eval #(
  parameter int N_IN = 14
) (
  input  logic [N_IN-1:0] vec,
  input  logic [N_IN-1:0] care,
  input  logic [N_IN-1:0] pol,
  output logic            f
);

  assign f = &(~care | (vec ~^ pol));

endmodule

// File: rtl/cube_scan_ctrl.sv
// Walks an inclusive vector range, streaming every minterm covered by a cube.
// Optional feature macro: CUBE_SCAN_EARLY_EXIT_EN (stop the scan at the first hit).
module cube_scan_ctrl
  import cube_scan_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_IN-1:0]   care,
  input  logic [N_IN-1:0]   pol,
  input  logic [N_IN-1:0]   lo,
  input  logic [N_IN-1:0]   hi,
  output logic              busy,
  output logic              hit_valid,
  output logic [N_IN-1:0]   hit_vec,
  input  logic              hit_ready,
  output logic              done,
  output logic [N_IN:0]     count
);

  localparam logic [N_IN-1:0] VEC_ONE = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE = {{N_IN{1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [N_IN-1:0]   vec, vec_n;
  logic [N_IN-1:0]   care_r, care_n;
  logic [N_IN-1:0]   pol_r, pol_n;
  logic [N_IN-1:0]   hi_r, hi_n;
  logic              hit_valid_n;
  logic [N_IN-1:0]   hit_vec_n;
  logic [N_IN:0]     count_n;
  logic              f;
  logic              stall;

  cube_eval #(.N_IN(N_IN)) u_eval (
    .vec  (vec),
    .care (care_r),
    .pol  (pol_r),
    .f    (f)
  );

  // A hit cannot be loaded while the previous one is still waiting downstream.
  assign stall = f & hit_valid & ~hit_ready;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      care_r    <= '0;
      pol_r     <= '0;
      hi_r      <= '0;
      hit_valid <= 1'b0;
      hit_vec   <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      care_r    <= care_n;
      pol_r     <= pol_n;
      hi_r      <= hi_n;
      hit_valid <= hit_valid_n;
      hit_vec   <= hit_vec_n;
      count     <= count_n;
    end
  end

  always_comb begin
    state_n     = state;
    vec_n       = vec;
    care_n      = care_r;
    pol_n       = pol_r;
    hi_n        = hi_r;
    hit_valid_n = hit_valid;
    hit_vec_n   = hit_vec;
    count_n     = count;

    if (hit_valid && hit_ready) begin
      hit_valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          care_n      = care;
          pol_n       = pol;
          hi_n        = hi;
          vec_n       = lo;
          count_n     = '0;
          hit_valid_n = 1'b0;
          state_n     = (lo > hi) ? DRAIN : SCAN;
        end
      end

      SCAN: begin
        if (abort) begin
          hit_valid_n = 1'b0;
          state_n     = IDLE;
        end else if (!stall) begin
          if (f) begin
            hit_vec_n   = vec;
            hit_valid_n = 1'b1;
            count_n     = count + CNT_ONE;
          end
          // vec is never incremented past hi, so hi = all-ones cannot wrap.
`ifdef CUBE_SCAN_EARLY_EXIT_EN
          if (f || (vec == hi_r)) begin
            state_n = DRAIN;
          end else begin
            vec_n = vec + VEC_ONE;
          end
`else
          if (vec == hi_r) begin
            state_n = DRAIN;
          end else begin
            vec_n = vec + VEC_ONE;
          end
`endif
        end
      end

      DRAIN: begin
        if (abort) begin
          hit_valid_n = 1'b0;
          state_n     = IDLE;
        end else if (!hit_valid || hit_ready) begin
          state_n = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Self-checking bench for cube_scan_ctrl: directed and random scans against a
// range-enumeration reference model. Honours CUBE_SCAN_EARLY_EXIT_EN.
module tb_cube_scan_ctrl;
  import cube_scan_pkg::*;

  localparam int N = N_IN_DEFAULT;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [N-1:0]   care, pol, lo, hi;
  logic           busy;
  logic           hit_valid;
  logic [N-1:0]   hit_vec;
  logic           hit_ready;
  logic           done;
  logic [N:0]     count;

  int checks = 0;
  int errors = 0;

  cube_scan_ctrl #(.N_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .care      (care),
    .pol       (pol),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .hit_valid (hit_valid),
    .hit_vec   (hit_vec),
    .hit_ready (hit_ready),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every vector in [l,h] whose cared-for bits equal pol is an onset minterm.
  // ready_mode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles after first hit.
  task automatic run_scan(input string tag, input int c, input int p, input int l, input int h,
                          input int ready_mode);
    int exp_q[$];
    int obs_q[$];
    int exp_done, cyc, done_cyc, done_cnt, low_left, first_bad, budget;
    bit seen_first;
    logic [N:0] held_count;

    for (int v = l; v <= h; v++) begin
      if (((v ^ p) & c) == 0) exp_q.push_back(v);
    end
`ifdef CUBE_SCAN_EARLY_EXIT_EN
    if (exp_q.size() > 1) exp_q = exp_q[0:0];
    exp_done = (l > h) ? 2 : ((exp_q.size() > 0) ? (exp_q[0] - l + 1 + 2) : (h - l + 1 + 2));
`else
    exp_done = (l > h) ? 2 : (h - l + 1 + 2);
`endif
    budget = (l > h) ? 20 : ((ready_mode == 0) ? (h - l + 12) : ((h - l + 1) * 8 + 64));

    care = N'(c); pol = N'(p); lo = N'(l); hi = N'(h);
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    hit_ready = 1'b1;
    tick();
    cyc = 1;
    start = 1'b0;
    abort = 1'b0;
    care = N'($urandom); pol = N'($urandom); lo = N'($urandom); hi = N'($urandom);
    check({tag, " busy"}, 32'(busy), 32'd1);

    done_cyc = -1; done_cnt = 0; low_left = 0; seen_first = 0;
    while (done_cyc < 0 && cyc < budget) begin
      case (ready_mode)
        0: hit_ready = 1'b1;
        1: hit_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (hit_valid && !seen_first) begin
            seen_first = 1;
            low_left = 3;
          end
          hit_ready = (low_left == 0);
          if (low_left > 0) low_left--;
        end
      endcase
      if (hit_valid && hit_ready) obs_q.push_back(int'(hit_vec));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        start = 1'b0;
      end else begin
        start = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
    end
    start = 1'b0;

    if (done_cyc < 0) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      return;
    end

    check({tag, " hit_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (first_bad < 0 && obs_q[i] != exp_q[i]) first_bad = i;
    end
    check({tag, " hit_seq_first_bad"}, 32'(first_bad), 32'hFFFF_FFFF);
    check({tag, " count"}, 32'(count), 32'(exp_q.size()));
    if (ready_mode == 0) check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));

    held_count = count;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " count_held"}, 32'(count), 32'(held_count));
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; hit_ready = 1'b1;
    care = '0; pol = '0; lo = '0; hi = '0;
    tick(); tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst hit_valid", 32'(hit_valid), 32'd0);
    check("rst hit_vec", 32'(hit_vec), 32'd0);
    check("rst count", 32'(count), 32'd0);
    rst = 1'b0;
    tick();

    run_scan("full", 32'h3FFF, 32'h3E68, 0, 32'h3FFF, 0);
    run_scan("dontcare", 32'h0003, 32'h0001, 0, 15, 0);
    run_scan("backpressure", 0, 0, 4, 7, 2);
    run_scan("top_edge", 32'h3FFF, 32'h3FFF, 32'h3FFF, 32'h3FFF, 0);
    run_scan("empty", 0, 0, 5, 3, 0);
    run_scan("early", 0, 0, 0, 100, 0);
    run_scan("random_bp", 0, 0, 200, 260, 1);

    for (int t = 0; t < 6; t++) begin
      int rl, rh;
      rl = $urandom_range(0, 32'h3FFF);
      rh = (t == 5) ? (rl - 1) : rl + $urandom_range(0, 150);
      if (rh > 32'h3FFF) rh = 32'h3FFF;
      if (rh < 0) rh = 0;
      run_scan($sformatf("rand%0d", t), int'($urandom & $urandom & 32'h3FFF),
               int'($urandom & 32'h3FFF), rl, rh, t % 2);
    end

    // Abort on the third SCAN cycle; every vector is a hit so two hits precede it.
    care = '0; pol = '0; lo = N'(10); hi = N'(60); hit_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hit_valid", 32'(hit_valid), 32'd0);
    check("abort count", 32'(count), 32'd2);
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) dcnt++;
      tick();
    end
    check("abort no_done", 32'(dcnt), 32'd0);

    // Reset in the middle of a long scan.
    care = '0; lo = '0; hi = N'(32'h3FFF);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    #2;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst hit_valid", 32'(hit_valid), 32'd0);
    check("midrst hit_vec", 32'(hit_vec), 32'd0);
    check("midrst count", 32'(count), 32'd0);
    tick(); rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done || hit_valid || busy) dcnt++;
    end
    check("midrst quiet", 32'(dcnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cube_scan_ctrl.md
CUBE_SCAN_CTRL -- requirements
Module: cube_scan_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 14, width of cube input vector.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  scan request, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous abort of a running scan.
REQ-006 SHALL have ports care, pol  input  N_IN each  cube care mask / literal polarity, latched on accepted start.
REQ-007 SHALL have ports lo, hi  input  N_IN each  inclusive vector range, latched on accepted start.
REQ-008 SHALL have port busy  output  1  high from cycle after accepted start until return to IDLE.
REQ-009 SHALL have ports hit_valid, hit_vec  output  1, N_IN  onset-minterm stream; hit_ready input 1.
REQ-010 SHALL have ports done, count  output  1, N_IN+1  one-cycle completion pulse, onset count.

Function
REQ-011 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-012 SHALL in IDLE on start=1: latch care/pol/lo/hi, clear count, load vec=lo, enter SCAN; if lo>hi enter DRAIN directly with count=0.
REQ-013 SHALL evaluate f = AND over i of (~care[i] | (vec[i] ~^ pol[i])) combinationally on current vec each SCAN cycle.
REQ-014 SHALL advance vec by one per SCAN cycle unless stalled; stall = f & hit_valid & ~hit_ready.
REQ-015 SHALL on non-stalled f=1: load hit_vec=vec, set hit_valid next cycle, increment count.
REQ-016 SHALL clear hit_valid on hit_valid&hit_ready unless a new hit is loaded same cycle.
REQ-017 SHALL leave SCAN for DRAIN when vec==hi advances, without incrementing vec past hi (no wrap at hi=all-ones).
REQ-018 SHALL move DRAIN->DONE when ~hit_valid | hit_ready; DONE asserts done for exactly one cycle, then IDLE.
REQ-019 SHALL, with hit_ready tied high and K=hi-lo+1 vectors, assert done exactly K+2 cycles after the start cycle.
REQ-020 SHALL hold count stable from DONE until next accepted start; count never overflows (max 2^N_IN).
REQ-021 SHALL on abort in SCAN/DRAIN go to IDLE next cycle, clear hit_valid, not assert done; abort wins over hit.
REQ-022 SHALL ignore start while busy; start and abort both high in IDLE: abort ignored, start accepted.

Reset
REQ-023 SHALL on rst: state IDLE, busy=0, done=0, hit_valid=0, hit_vec=0, count=0, internal vec/config registers 0.
REQ-024 SHALL abandon a scan in progress on rst with no done pulse and no further hits.

Configuration
REQ-025 SHALL honour macro CUBE_SCAN_EARLY_EXIT_EN: defined -> first non-stalled hit sends SCAN->DRAIN (count<=1); undefined -> full range always scanned.

Structure
REQ-026 SHALL place N_IN default, state enum type and count width constant in package cube_scan_pkg.
REQ-027 SHALL instantiate combinational sub-module cube_eval (vec, care, pol -> f) as the evaluated datapath.

Verification
REQ-028 Full scan: care=0x3FFF, pol=0x3E68, lo=0, hi=0x3FFF, hit_ready=1 -> one hit, hit_vec=0x3E68, count=1, done at cycle 16386.
REQ-029 Don't-cares: care=0x0003, pol=0x0001, lo=0, hi=15 -> hits 1,5,9,13 in order, count=4, done at cycle 18.
REQ-030 Backpressure: care=0, lo=4, hi=7, hit_ready low 3 cycles after first hit -> hits 4,5,6,7 each once, none lost/duplicated, count=4.
REQ-031 Boundaries: lo=hi=0x3FFF with matching cube -> count=1, no wrap; lo=5, hi=3 -> no hits, count=0, done one pulse.
REQ-032 Abort/reset: abort at 3rd SCAN cycle -> IDLE, hit_valid=0, no done; rst mid-scan -> all outputs at reset values.
REQ-033 Macro: with CUBE_SCAN_EARLY_EXIT_EN, care=0, lo=0, hi=100 -> single hit 0, count=1, done at cycle 3.
